// File: rtl/ifetch.sv
// Instruction fetch stage: PC, IM_ID/ID_EX next-PC pipeline, fetch counter.
// Define IM_WAIT_EN to add the im_rdy handshake, FETCH/WAIT machine and timeout flag.
module ifetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_IM_ID,
    input  logic        flow_change_ID_EX,
    input  logic [15:0] dst_ID_EX,
    output logic [15:0] iaddr,
    input  logic [31:0] im_rdata,
    input  logic        im_rdy,
    output logic [31:0] instr,
    output logic [15:0] nxt_pc_ID_EX,
    output logic [31:0] fetch_cnt,
    output logic        im_err
);

    localparam logic [31:0] NOP = 32'h0000_B000;

    logic [15:0] r_pc;
    logic [15:0] r_nxt_pc_im_id;
    logic [15:0] r_nxt_pc_id_ex;
    logic [31:0] r_fetch_cnt;
    logic [15:0] w_pc_inc;
    logic        w_vf;

    assign w_pc_inc = r_pc + 16'd1;

`ifdef IM_WAIT_EN
    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_wait_stay;
    logic [7:0]  r_wait_cnt;
    logic        r_im_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a redirect always lands in FETCH so the new address is retried
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (!im_rdy && !flow_change_ID_EX) w_state_nxt = S_WAIT;
                else                               w_state_nxt = S_FETCH;
            end
            S_WAIT: begin
                if (im_rdy || flow_change_ID_EX) w_state_nxt = S_FETCH;
                else                             w_state_nxt = S_WAIT;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Outputs: ready data in WAIT is the return-to-FETCH cycle and is delivered
    always_comb begin
        w_vf        = 1'b0;
        w_wait_stay = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_vf        = im_rdy;
                w_wait_stay = 1'b0;
            end
            S_WAIT: begin
                w_vf        = im_rdy;
                w_wait_stay = !im_rdy && !flow_change_ID_EX;
            end
            default: begin
                w_vf        = 1'b0;
                w_wait_stay = 1'b0;
            end
        endcase
    end

    // Consecutive-wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
            r_im_err   <= 1'b0;
        end else begin
            if (w_wait_stay) begin
                if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
                else                     r_wait_cnt <= r_wait_cnt;
            end else begin
                r_wait_cnt <= 8'd0;
            end
            if (w_wait_stay && (r_wait_cnt == 8'hFE)) r_im_err <= 1'b1;
            else                                      r_im_err <= r_im_err;
        end
    end

    assign im_err = r_im_err;
`else
    logic w_unused_im_rdy;

    assign w_unused_im_rdy = im_rdy;
    assign w_vf            = 1'b1;
    assign im_err          = 1'b0;
`endif

    // PC, next-PC pipeline and accepted-fetch counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= 16'h0000;
            r_nxt_pc_im_id <= 16'h0001;
            r_nxt_pc_id_ex <= 16'h0000;
            r_fetch_cnt    <= 32'd0;
        end else begin
            if (flow_change_ID_EX) r_pc <= dst_ID_EX;
            else if (stall_IM_ID)  r_pc <= r_pc;
            else if (w_vf)         r_pc <= w_pc_inc;
            else                   r_pc <= r_pc;

            // NOP slots carry PC+1 as well, so only a stall freezes this stage
            if (stall_IM_ID) r_nxt_pc_im_id <= r_nxt_pc_im_id;
            else             r_nxt_pc_im_id <= w_pc_inc;

            r_nxt_pc_id_ex <= r_nxt_pc_im_id;

            if (w_vf && !stall_IM_ID && !flow_change_ID_EX) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            else                                            r_fetch_cnt <= r_fetch_cnt;
        end
    end

    // Instruction mux to decode
    always_comb begin
        if (w_vf) instr = im_rdata;
        else      instr = NOP;
    end

    assign iaddr        = r_pc;
    assign nxt_pc_ID_EX = r_nxt_pc_id_ex;
    assign fetch_cnt    = r_fetch_cnt;

endmodule
